// File: rtl/ex_mdu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ex_mdu                                                        |
// | Purpose  : Multi-cycle RV32M multiply/divide unit for the EX stage.      |
// |            Radix-2 shift-add multiply, restoring divide, one bit per     |
// |            clock. Requests use a valid/ready handshake. The response is  |
// |            a valid/ready port that carries the rd write-back. Flush      |
// |            aborts the operation in progress.                             |
// | Ports    : clk, rst (async, active-high), flush_i                        |
// |            req_valid_i/req_ready_o, funct3_i, op1_i, op2_i, rd_addr_i    |
// |            resp_valid_o/resp_ready_i, regs_wen_o, rd_addr_o, rd_data_o   |
// |            busy_o                                                        |
// | Config   : MDU_FAST_MUL_EN - all multiplies finish in one cycle on a     |
// |            full XLEN x XLEN multiplier. Divide is unchanged.             |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module ex_mdu #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [2:0]            funct3_i,
  input  logic [XLEN-1:0]       op1_i,
  input  logic [XLEN-1:0]       op2_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic                  regs_wen_o,
  output logic [REG_ADDR_W-1:0] rd_addr_o,
  output logic [XLEN-1:0]       rd_data_o,
  output logic                  busy_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [CNT_W-1:0] c_last    = CNT_W'(XLEN - 1);
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
  localparam logic [XLEN-1:0]  c_min     = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]            r_state;
  logic [1:0]            w_state_next;
  logic [CNT_W-1:0]      r_cnt;
  // Upper half: partial product / partial remainder.
  // Lower half: multiplier / dividend, shifted out one bit per cycle.
  logic [2*XLEN-1:0]     r_acc;
  logic [XLEN-1:0]       r_opb;      // multiplicand or divisor magnitude
  logic [XLEN-1:0]       r_result;
  logic [REG_ADDR_W-1:0] r_rd_addr;
  logic                  r_neg;      // negate the final magnitude
  logic                  r_sel;      // mul: take low half; div: take remainder

  // ---------------- request decode ----------------
  logic            w_idle, w_accept, w_is_div;
  logic            w_op1_signed, w_op2_signed, w_neg1, w_neg2;
  logic [XLEN-1:0] w_mag1, w_mag2;
  logic            w_div_zero, w_div_ovf, w_fast, w_short;
  logic            w_sel, w_neg;
  logic [XLEN-1:0] w_fast_result, w_short_result;

  assign w_idle       = (r_state == S_IDLE);
  assign w_accept     = req_valid_i & w_idle & ~flush_i;
  assign w_is_div     = funct3_i[2];
  assign w_op1_signed = (funct3_i == 3'd1) | (funct3_i == 3'd2) |
                        (funct3_i == 3'd4) | (funct3_i == 3'd6);
  assign w_op2_signed = (funct3_i == 3'd1) | (funct3_i == 3'd4) | (funct3_i == 3'd6);
  assign w_neg1       = w_op1_signed & op1_i[XLEN-1];
  assign w_neg2       = w_op2_signed & op2_i[XLEN-1];
  assign w_mag1       = w_neg1 ? (~op1_i + 1'b1) : op1_i;
  assign w_mag2       = w_neg2 ? (~op2_i + 1'b1) : op2_i;

  // DIV and REM are the signed divides (funct3 bit 0 clear).
  assign w_div_zero = w_is_div & (op2_i == '0);
  assign w_div_ovf  = w_is_div & ~funct3_i[0] & (op1_i == c_min) & (op2_i == '1);

  assign w_sel = w_is_div ? funct3_i[1] : (funct3_i[1:0] == 2'd0);
  // The remainder takes the sign of the dividend. The quotient and the
  // product take the XOR of the operand signs.
  assign w_neg = (w_is_div & funct3_i[1]) ? w_neg1 : (w_neg1 ^ w_neg2);

`ifdef MDU_FAST_MUL_EN
  // Sign-extend both operands to 2*XLEN. The low 2*XLEN bits of the
  // unsigned product then equal the exact two's-complement product.
  logic [2*XLEN-1:0] w_fa, w_fb, w_fprod;
  assign w_fa          = {{XLEN{w_neg1}}, op1_i};
  assign w_fb          = {{XLEN{w_neg2}}, op2_i};
  assign w_fprod       = w_fa * w_fb;
  assign w_fast        = ~w_is_div;
  assign w_fast_result = (funct3_i[1:0] == 2'd0) ? w_fprod[XLEN-1:0] : w_fprod[2*XLEN-1:XLEN];
`else
  assign w_fast        = 1'b0;
  assign w_fast_result = '0;
`endif

  assign w_short = w_div_zero | w_div_ovf | w_fast;
  always_comb begin
    w_short_result = w_fast_result;
    if (w_div_zero)
      w_short_result = funct3_i[1] ? op1_i : '1;
    else if (w_div_ovf)
      w_short_result = funct3_i[1] ? '0 : op1_i;
  end

  // ---------------- iteration datapath ----------------
  logic              w_last;
  logic [XLEN-1:0]   w_addend;
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_next, w_mul_signed;
  logic [XLEN-1:0]   w_mul_res;
  logic [XLEN+1:0]   w_div_sub;
  logic              w_div_ok;
  logic [2*XLEN-1:0] w_div_next;
  logic [XLEN-1:0]   w_div_val, w_div_res;

  assign w_last = (r_cnt == c_last);

  // Shift-add step: add the multiplicand when the multiplier LSB is set,
  // then shift the carry, high half and low half right by one.
  assign w_addend     = r_acc[0] ? r_opb : '0;
  assign w_mul_sum    = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, w_addend};
  assign w_mul_next   = {w_mul_sum, r_acc[XLEN-1:1]};
  assign w_mul_signed = r_neg ? (~w_mul_next + 1'b1) : w_mul_next;
  assign w_mul_res    = r_sel ? w_mul_signed[XLEN-1:0] : w_mul_signed[2*XLEN-1:XLEN];

  // Restoring step: shift in the next dividend bit and try to subtract the
  // divisor. Keep the difference and record a 1 only if it is non-negative.
  assign w_div_sub  = {1'b0, r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]} - {2'b00, r_opb};
  assign w_div_ok   = ~w_div_sub[XLEN+1];
  assign w_div_next = w_div_ok ? {w_div_sub[XLEN-1:0], r_acc[XLEN-2:0], 1'b1}
                               : {r_acc[2*XLEN-2:0], 1'b0};
  assign w_div_val  = r_sel ? w_div_next[2*XLEN-1:XLEN] : w_div_next[XLEN-1:0];
  assign w_div_res  = r_neg ? (~w_div_val + 1'b1) : w_div_val;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept)
          w_state_next = w_short ? S_DONE : (w_is_div ? S_DIV : S_MUL);
      end
      S_MUL, S_DIV: begin
        if (flush_i)     w_state_next = S_IDLE;
        else if (w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        if (flush_i | resp_ready_i) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    req_ready_o  = w_idle & ~flush_i;
    resp_valid_o = (r_state == S_DONE);
    busy_o       = ~w_idle;
    regs_wen_o   = (r_state == S_DONE) & (r_rd_addr != '0);
    rd_addr_o    = r_rd_addr;
    rd_data_o    = r_result;
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_opb     <= '0;
      r_result  <= '0;
      r_rd_addr <= '0;
      r_neg     <= 1'b0;
      r_sel     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_rd_addr <= rd_addr_i;
            r_sel     <= w_sel;
            r_neg     <= w_neg;
            r_cnt     <= '0;
            r_acc     <= {{XLEN{1'b0}}, w_mag1};
            r_opb     <= w_mag2;
            if (w_short) r_result <= w_short_result;
          end
        end
        S_MUL: begin
          if (!flush_i) begin
            r_acc <= w_mul_next;
            r_cnt <= r_cnt + c_cnt_one;
            if (w_last) r_result <= w_mul_res;
          end
        end
        S_DIV: begin
          if (!flush_i) begin
            r_acc <= w_div_next;
            r_cnt <= r_cnt + c_cnt_one;
            if (w_last) r_result <= w_div_res;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
